qam_sym_scheduler: RTL and testbench
====================================

# qam_sym_scheduler

Symbol scheduler in front of the QAM-16 modulator. It accepts a framed byte stream and splits each byte into two 4-bit symbols, high nibble first. Each symbol is held on the modulator's `data_in` for exactly SPS sample clocks. Every frame is wrapped in a fixed preamble and a trailing guard gap, and nothing starts until the modulator reports `qam_valid`.

## Interface
- `SPS`, default 128: samples per symbol (hold cycles); legal range 4..65535.
- `PREAMBLE_LEN`, default 8: preamble symbols per frame; legal range 1..255.
- `GAP_SYMS`, default 4: guard symbols after a frame; legal range 1..255.

- `axi_clk`  in  1  sole clock.
- `axi_rst`  in  1  reset; synchronous, active-high.
- `s_tdata`  in  8  payload byte.
- `s_tvalid`  in  1  byte valid.
- `s_tlast`  in  1  last byte of frame; qualified by `s_tvalid`.
- `s_tready`  out  1  byte accepted when `s_tvalid && s_tready`.
- `mod_ready`  in  1  modulator `qam_valid`.
- `sym_out`  out  4  symbol to modulator `data_in`.
- `sym_stb`  out  1  one-cycle pulse on the first sample of every symbol.
- `sym_en`  out  1  high while `sym_out` carries preamble or payload.
- `busy`  out  1  high in any state other than IDLE.
- `underrun`  out  1  one-cycle pulse when a payload symbol is due and no byte is buffered.

## Operation
- **Input buffer.** One-entry buffer: `byte_q`, `last_q`, `byte_vld`.
  - `s_tready = !byte_vld && !frame_closed && state != GAP`.
  - `frame_closed` sets when a byte is accepted with `s_tlast` high. It clears on entry to IDLE.
- **Counters.**
  - `samp_cnt` runs 0..SPS-1. A boundary occurs when `samp_cnt == SPS-1`.
  - `sym_cnt` counts preamble and gap symbols.
  - `nib_sel` selects the nibble: 0 = high, 1 = low.
- **IDLE**
  - `sym_out` = 0, `sym_en` = 0.
  - Move to PREAMBLE when `byte_vld && mod_ready`. `mod_ready` is sampled only in IDLE.
- **PREAMBLE**
  - Emits PREAMBLE_LEN symbols alternating 4'hF, 4'h0, starting with F.
  - After the last preamble symbol's boundary, moves to PAYLOAD.
- **PAYLOAD.** At each boundary (and on entry):
  - If `byte_vld`: load the `byte_q` nibble selected by `nib_sel`, then toggle `nib_sel`.
  - Loading the low nibble clears `byte_vld`. If `last_q` was set, the next boundary moves to GAP.
  - If `!byte_vld`: load 4'h0, pulse `underrun`, leave `nib_sel` unchanged, and keep `sym_en` high.
- **GAP**
  - GAP_SYMS symbols of 4'h0 with `sym_en` = 0.
  - After the final boundary, returns to IDLE and clears `frame_closed` and `nib_sel`.
- **Reset.** `axi_rst` at any time gives the following on the next edge:
  - state IDLE;
  - all counters 0;
  - `byte_vld` = 0 and `frame_closed` = 0; the buffered byte is discarded;
  - outputs `sym_out` = 0, `sym_stb` = 0, `sym_en` = 0, `busy` = 0, `underrun` = 0;
  - `s_tready` = 1 from the first post-reset cycle.

## Timing
- All outputs are registered except `s_tready`, which is combinational from registered state.
- Accept at edge t sets `byte_vld` at t+1. In IDLE with `mod_ready`, the first symbol appears on `sym_out` at t+2 with `sym_stb` = 1 and `samp_cnt` = 0.
- Every symbol is held exactly SPS cycles. `sym_stb` is high only on the first of them.
- The buffer frees on the low-nibble load. `s_tready` rises the following cycle, giving SPS-1 cycles to refill before the next byte's high nibble is due without underrun.
- A byte presented while `byte_vld` = 0 in IDLE, PREAMBLE or PAYLOAD is accepted. It is not presented to `sym_out` until the next boundary.
- A simultaneous boundary and accept in PAYLOAD uses the pre-edge `byte_vld`. The new byte arrives one edge late, so the result is an underrun symbol.

## Configuration
- `QAM_SCHED_PREAMBLE_EN` defined: PREAMBLE state present, as above.
- `QAM_SCHED_PREAMBLE_EN` undefined:
  - PREAMBLE state and `PREAMBLE_LEN` logic are removed.
  - IDLE goes directly to PAYLOAD, and the first symbol is the first byte's high nibble.

## Structure
- Shared package `qam_pkg`:
  - `typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} sched_state_t`;
  - symbol width constant `QAM_SYM_W` = 4;
  - preamble constants `PRE_SYM_A` = 4'hF and `PRE_SYM_B` = 4'h0.
- One sub-module, `qam_sym_timer`: the SPS sample counter producing the boundary and `sym_stb`. It is cleared on IDLE or reset.
- The state machine and input buffer live in the top module.

## Test plan
All scenarios use SPS=4, PREAMBLE_LEN=2, GAP_SYMS=1.
- **Single byte.** One-byte frame 0xA5 with `s_tlast` and `mod_ready` = 1 → `sym_out` holds F,0,A,5, 4 cycles each. `sym_stb` pulses every 4 cycles. `sym_en` is then low for 4 gap cycles, and `busy` falls after them.
- **Multi-byte.** Frame 0x12,0x34 with `s_tvalid` always high → symbols F,0,1,2,3,4 back-to-back, no `underrun`. `s_tready` is low from the last accept until IDLE.
- **Underrun.** Second byte delayed 10 cycles → symbol 0 inserted with one `underrun` pulse. Then 3,4 follow and the frame completes.
- **mod_ready gating.** `mod_ready` = 0 with a byte buffered → stays IDLE, `sym_en` = 0, `s_tready` = 0. Raising `mod_ready` → first F appears 1 cycle later.
- **Reset mid-frame.** `axi_rst` pulsed during a payload symbol → next cycle all outputs are 0 and `s_tready` = 1. A new frame then runs correctly.
- **Build without the macro.** `QAM_SCHED_PREAMBLE_EN` undefined, byte 0xA5 → symbols A,5 only, with first `sym_stb` 2 cycles after accept.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM-16 symbol scheduler.
package qam_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} sched_state_t;

  localparam int unsigned QAM_SYM_W = 4;

  localparam logic [QAM_SYM_W-1:0] PRE_SYM_A = 4'hF;
  localparam logic [QAM_SYM_W-1:0] PRE_SYM_B = 4'h0;

endpackage

// File: rtl/qam_sym_timer.sv
// Per-symbol sample counter: flags the last sample of a symbol and registers the
// first-sample strobe for every symbol the scheduler loads.
module qam_sym_timer #(
  parameter int unsigned SPS = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic sym_load,
  output logic boundary,
  output logic sym_stb
);

  logic [15:0] samp_cnt;

  assign boundary = run && (samp_cnt == 16'(SPS - 1));

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      samp_cnt <= '0;
    end else if (boundary) begin
      samp_cnt <= '0;
    end else begin
      samp_cnt <= samp_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_stb <= 1'b0;
    end else begin
      sym_stb <= sym_load;
    end
  end

endmodule

// File: rtl/qam_sym_scheduler.sv
// Frames a byte stream into held QAM-16 symbols (preamble, payload nibbles, guard gap).
// Define QAM_SCHED_PREAMBLE_EN to emit the alternating preamble before each payload.
module qam_sym_scheduler
  import qam_pkg::*;
#(
  parameter int unsigned SPS          = 128,
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned GAP_SYMS     = 4
) (
  input  logic                 axi_clk,
  input  logic                 axi_rst,
  input  logic [7:0]           s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,
  input  logic                 mod_ready,
  output logic [QAM_SYM_W-1:0] sym_out,
  output logic                 sym_stb,
  output logic                 sym_en,
  output logic                 busy,
  output logic                 underrun
);

  sched_state_t state, state_d;

  logic [7:0]           byte_q, byte_d;
  logic                 last_q, last_d;
  logic                 byte_vld, byte_vld_d;
  logic                 frame_closed, frame_closed_d;
  logic                 nib_sel, nib_sel_d;
  logic                 last_loaded, last_loaded_d;
  logic [7:0]           sym_cnt, sym_cnt_d;
  logic [QAM_SYM_W-1:0] sym_out_d;
  logic                 sym_en_d;
  logic                 underrun_d;
  logic                 sym_load;
  logic                 pay_load;
  logic                 boundary;
  logic                 accept;

  assign s_tready = !byte_vld && !frame_closed && (state != GAP);
  assign accept   = s_tvalid && s_tready;

  qam_sym_timer #(
    .SPS (SPS)
  ) u_timer (
    .clk      (axi_clk),
    .rst      (axi_rst),
    .run      (state != IDLE),
    .sym_load (sym_load),
    .boundary (boundary),
    .sym_stb  (sym_stb)
  );

  always_comb begin
    state_d        = state;
    byte_d         = byte_q;
    last_d         = last_q;
    byte_vld_d     = byte_vld;
    frame_closed_d = frame_closed;
    nib_sel_d      = nib_sel;
    last_loaded_d  = last_loaded;
    sym_cnt_d      = sym_cnt;
    sym_out_d      = sym_out;
    sym_en_d       = sym_en;
    underrun_d     = 1'b0;
    sym_load       = 1'b0;
    pay_load       = 1'b0;

    if (accept) begin
      byte_d     = s_tdata;
      last_d     = s_tlast;
      byte_vld_d = 1'b1;
      if (s_tlast) begin
        frame_closed_d = 1'b1;
      end
    end

    unique case (state)
      IDLE: begin
        sym_out_d = '0;
        sym_en_d  = 1'b0;
        if (byte_vld && mod_ready) begin
          sym_load = 1'b1;
`ifdef QAM_SCHED_PREAMBLE_EN
          state_d   = PREAMBLE;
          sym_cnt_d = '0;
          sym_out_d = PRE_SYM_A;
          sym_en_d  = 1'b1;
`else
          pay_load  = 1'b1;
`endif
        end
      end
`ifdef QAM_SCHED_PREAMBLE_EN
      PREAMBLE: begin
        if (boundary) begin
          sym_load = 1'b1;
          if (sym_cnt == 8'(PREAMBLE_LEN - 1)) begin
            pay_load = 1'b1;
          end else begin
            sym_cnt_d = sym_cnt + 8'd1;
            sym_out_d = sym_cnt[0] ? PRE_SYM_A : PRE_SYM_B;
          end
        end
      end
`endif
      PAYLOAD: begin
        if (boundary) begin
          sym_load = 1'b1;
          if (last_loaded) begin
            state_d       = GAP;
            sym_cnt_d     = '0;
            sym_out_d     = '0;
            sym_en_d      = 1'b0;
            last_loaded_d = 1'b0;
          end else begin
            pay_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (boundary) begin
          if (sym_cnt == 8'(GAP_SYMS - 1)) begin
            state_d        = IDLE;
            frame_closed_d = 1'b0;
            nib_sel_d      = 1'b0;
            sym_cnt_d      = '0;
          end else begin
            sym_load  = 1'b1;
            sym_cnt_d = sym_cnt + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Payload slot: uses the pre-edge buffer, so a byte accepted on this edge is late.
    if (pay_load) begin
      state_d  = PAYLOAD;
      sym_en_d = 1'b1;
      if (byte_vld) begin
        sym_out_d = nib_sel ? byte_q[3:0] : byte_q[7:4];
        nib_sel_d = !nib_sel;
        if (nib_sel) begin
          byte_vld_d    = 1'b0;
          last_loaded_d = last_q;
        end
      end else begin
        sym_out_d  = '0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state        <= IDLE;
      byte_q       <= '0;
      last_q       <= 1'b0;
      byte_vld     <= 1'b0;
      frame_closed <= 1'b0;
      nib_sel      <= 1'b0;
      last_loaded  <= 1'b0;
      sym_cnt      <= '0;
      sym_out      <= '0;
      sym_en       <= 1'b0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      byte_vld     <= byte_vld_d;
      frame_closed <= frame_closed_d;
      nib_sel      <= nib_sel_d;
      last_loaded  <= last_loaded_d;
      sym_cnt      <= sym_cnt_d;
      sym_out      <= sym_out_d;
      sym_en       <= sym_en_d;
      busy         <= (state_d != IDLE);
      underrun     <= underrun_d;
    end
  end

endmodule

// File: tb/tb_qam_sym_scheduler.sv
// Bench for qam_sym_scheduler: directed frames plus random frames, each checked against
// the symbol stream expected from the frame contents (preamble, nibbles, gap).
module tb_qam_sym_scheduler;

  localparam int unsigned SPS_T = 4;
  localparam int unsigned PRE_LEN = 2;
  localparam int unsigned GAP_T = 1;
`ifdef QAM_SCHED_PREAMBLE_EN
  localparam int unsigned PRE_N = PRE_LEN;
`else
  localparam int unsigned PRE_N = 0;
`endif

  typedef logic [7:0] bq_t[$];

  logic       axi_clk = 1'b0;
  logic       axi_rst = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic       mod_ready = 1'b1;
  logic [3:0] sym_out;
  logic       sym_stb;
  logic       sym_en;
  logic       busy;
  logic       underrun;

  int checks = 0;
  int failures = 0;

  qam_sym_scheduler #(
    .SPS          (SPS_T),
    .PREAMBLE_LEN (PRE_LEN),
    .GAP_SYMS     (GAP_T)
  ) dut (
    .axi_clk   (axi_clk),
    .axi_rst   (axi_rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .mod_ready (mod_ready),
    .sym_out   (sym_out),
    .sym_stb   (sym_stb),
    .sym_en    (sym_en),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 axi_clk = ~axi_clk;

  // Symbol monitor: one entry per strobe, with the measured hold length of each symbol.
  logic [3:0] sym_q[$];
  logic       en_q[$];
  logic       und_q[$];
  int         len_q[$];
  logic       stab_q[$];
  logic       mon_clr = 1'b0;
  logic       mon_open = 1'b0;
  int         cur_len = 0;
  logic [3:0] cur_sym = '0;
  logic       cur_stab = 1'b1;
  int         und_total = 0;

  always @(negedge axi_clk) begin
    if (mon_clr) begin
      sym_q.delete();
      en_q.delete();
      und_q.delete();
      len_q.delete();
      stab_q.delete();
      und_total <= 0;
      mon_open  <= 1'b0;
    end else if (axi_rst) begin
      mon_open <= 1'b0;
    end else begin
      if (underrun === 1'b1) und_total <= und_total + 1;
      if (sym_stb === 1'b1) begin
        if (mon_open) begin
          len_q.push_back(cur_len);
          stab_q.push_back(cur_stab);
        end
        mon_open <= 1'b1;
        cur_len  <= 1;
        cur_sym  <= sym_out;
        cur_stab <= 1'b1;
        sym_q.push_back(sym_out);
        en_q.push_back(sym_en);
        und_q.push_back(underrun);
      end else if (mon_open) begin
        if (busy !== 1'b1) begin
          len_q.push_back(cur_len);
          stab_q.push_back(cur_stab);
          mon_open <= 1'b0;
        end else begin
          cur_len <= cur_len + 1;
          if (sym_out !== cur_sym) cur_stab <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge axi_clk);
    #1;
    mon_clr = 1'b0;
    @(posedge axi_clk);
    #1;
  endtask

  // Presents one byte after `gap` idle cycles; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int n;
    s_tvalid = 1'b0;
    repeat (gap) @(posedge axi_clk);
    #1;
    s_tvalid = 1'b1;
    s_tdata  = b;
    s_tlast  = last;
    n = 0;
    @(negedge axi_clk);
    while (!s_tready && n < 400) begin
      @(negedge axi_clk);
      n++;
    end
    if (!s_tready) chk("accept timeout", s_tready, 1);
    @(posedge axi_clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    while (busy && n < 2000) begin
      @(negedge axi_clk);
      n++;
    end
    chk({tag, " done"}, busy, 0);
    @(posedge axi_clk);
    #1;
  endtask

  task automatic check_stream(input bq_t bytes, input int exp_und, input string tag);
    logic [3:0] es[$];
    logic       ee[$];
    int         j;
    int         und;
    int         bad;
    for (int k = 0; k < int'(PRE_N); k++) begin
      es.push_back((k % 2 == 0) ? 4'hF : 4'h0);
      ee.push_back(1'b1);
    end
    foreach (bytes[k]) begin
      es.push_back(bytes[k][7:4]);
      ee.push_back(1'b1);
      es.push_back(bytes[k][3:0]);
      ee.push_back(1'b1);
    end
    for (int k = 0; k < int'(GAP_T); k++) begin
      es.push_back(4'h0);
      ee.push_back(1'b0);
    end
    j = 0;
    und = 0;
    for (int i = 0; i < sym_q.size(); i++) begin
      if (und_q[i]) begin
        und++;
        chk($sformatf("%s und_sym%0d", tag, i), {en_q[i], sym_q[i]}, 5'h10);
      end else if (j < es.size()) begin
        chk($sformatf("%s sym%0d", tag, i), {en_q[i], sym_q[i]}, {ee[j], es[j]});
        j++;
      end
    end
    chk({tag, " nsyms"}, sym_q.size() - und, es.size());
    bad = 0;
    foreach (len_q[i]) begin
      if (len_q[i] != int'(SPS_T) || !stab_q[i]) bad++;
    end
    chk({tag, " hold"}, bad, 0);
    chk({tag, " nholds"}, len_q.size(), sym_q.size());
    chk({tag, " und_pulses"}, und_total, und);
    if (exp_und >= 0) chk({tag, " und_count"}, und, exp_und);
  endtask

  initial begin
    bq_t        bytes;
    logic [3:0] first_sym;
    int         bad;
    int         n;
    int         nb;

    // Reset state
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst sym_out", sym_out, 0);
    chk("rst sym_stb", sym_stb, 0);
    chk("rst sym_en", sym_en, 0);
    chk("rst busy", busy, 0);
    chk("rst underrun", underrun, 0);
    chk("rst s_tready", s_tready, 1);
    axi_rst = 1'b0;
    @(posedge axi_clk);
    #1;

    // Single byte: first strobe two edges after accept
    clear_mon();
    first_sym = (PRE_N > 0) ? 4'hF : 4'hA;
    send_byte(8'hA5, 1'b1, 0);
    chk("single stb t+1", sym_stb, 0);
    @(posedge axi_clk);
    #1;
    chk("single stb t+2", sym_stb, 1);
    chk("single first sym", sym_out, first_sym);
    chk("single busy", busy, 1);
    wait_done("single");
    bytes = '{8'hA5};
    check_stream(bytes, 0, "single");

    // Multi-byte streamed back-to-back: no underrun, ready held low until idle
    clear_mon();
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b1, 0);
    bad = 0;
    n = 0;
    @(negedge axi_clk);
    while (busy && n < 2000) begin
      if (s_tready) bad++;
      @(negedge axi_clk);
      n++;
    end
    chk("multi tready low", bad, 0);
    chk("multi idle", busy, 0);
    chk("multi tready idle", s_tready, 1);
    @(posedge axi_clk);
    #1;
    bytes = '{8'h12, 8'h34};
    check_stream(bytes, 0, "multi");

    // Underrun: second byte accepted six edges after the buffer frees
    clear_mon();
    send_byte(8'h12, 1'b0, 0);
    n = 0;
    @(negedge axi_clk);
    while (!s_tready && n < 400) begin
      @(negedge axi_clk);
      n++;
    end
    chk("und ready", s_tready, 1);
    repeat (5) @(posedge axi_clk);
    #1;
    send_byte(8'h34, 1'b1, 0);
    wait_done("und");
    check_stream(bytes, 1, "und");

    // mod_ready gating
    clear_mon();
    mod_ready = 1'b0;
    send_byte(8'hC3, 1'b1, 0);
    repeat (6) @(posedge axi_clk);
    #1;
    chk("gate busy", busy, 0);
    chk("gate sym_en", sym_en, 0);
    chk("gate tready", s_tready, 0);
    mod_ready = 1'b1;
    @(posedge axi_clk);
    #1;
    chk("gate stb", sym_stb, 1);
    chk("gate first sym", sym_out, (PRE_N > 0) ? 4'hF : 4'hC);
    wait_done("gate");
    bytes = '{8'hC3};
    check_stream(bytes, 0, "gate");

    // Reset during a payload symbol
    clear_mon();
    send_byte(8'h5A, 1'b1, 0);
    repeat (2 + PRE_N * SPS_T + 1) @(posedge axi_clk);
    #1;
    chk("mid in payload", sym_en, 1);
    axi_rst = 1'b1;
    @(posedge axi_clk);
    #1;
    chk("mid rst sym_out", sym_out, 0);
    chk("mid rst sym_stb", sym_stb, 0);
    chk("mid rst sym_en", sym_en, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst underrun", underrun, 0);
    chk("mid rst tready", s_tready, 1);
    axi_rst = 1'b0;
    @(posedge axi_clk);
    #1;
    clear_mon();
    send_byte(8'h3C, 1'b1, 0);
    wait_done("post_rst");
    bytes = '{8'h3C};
    check_stream(bytes, 0, "post_rst");

    // Random frames with random inter-byte gaps
    for (int f = 0; f < 5; f++) begin
      clear_mon();
      bytes.delete();
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        bytes.push_back(8'($urandom));
        send_byte(bytes[k], (k == nb - 1), $urandom_range(0, 7));
      end
      wait_done($sformatf("rand%0d", f));
      check_stream(bytes, -1, $sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
